// File: rtl/sdram_pro_read_pkg.sv
// Shared SDRAM command codes, read-engine states and rd_addr field slices.
// The write engine reuses the same command codes and address slices.
package sdram_pro_read_pkg;

  // {CS_N, RAS_N, CAS_N, WE_N}
  localparam logic [3:0] CMD_NOP        = 4'b0111;
  localparam logic [3:0] CMD_ACTIVE     = 4'b0011;
  localparam logic [3:0] CMD_READ       = 4'b0101;
  localparam logic [3:0] CMD_BURST_TERM = 4'b0110;
  localparam logic [3:0] CMD_PRECHARGE  = 4'b0010;

  localparam int BANK_HI = 22;
  localparam int BANK_LO = 21;
  localparam int ROW_HI  = 20;
  localparam int ROW_LO  = 9;
  localparam int COL_HI  = 8;
  localparam int COL_LO  = 0;

  localparam logic [9:0]  MAX_BURST     = 10'd512;
  localparam logic [11:0] PRECHARGE_ALL = 12'h400;

  typedef enum logic [3:0] {
    RD_IDLE,
    RD_ACTIVE,
    RD_TRCD,
    RD_READ,
    RD_READ_DATA,
    RD_TERMINATE,
    RD_PRECHARGE,
    RD_TRP,
    RD_END
  } rd_state_t;

  function automatic logic [9:0] clamp_burst(input logic [9:0] len);
    if (len == 10'd0)
      return 10'd1;
    else if (len > MAX_BURST)
      return MAX_BURST;
    else
      return len;
  endfunction

endpackage

// File: rtl/sdram_pro_read_capture.sv
// Read-data capture: a CAS_LAT-deep valid pipeline aligns each issued column
// with its word on DQ and registers it into rd_data with rd_ack.
module sdram_pro_rd_capture #(
  parameter int CAS_LAT = 3
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic        issue,
  input  logic [15:0] rd_sdram_data,
  output logic        busy,
  output logic        rd_ack,
  output logic [15:0] rd_data
);

  logic [CAS_LAT-1:0] valid_sr;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      valid_sr <= '0;
      rd_ack   <= 1'b0;
      rd_data  <= 16'h0;
    end else begin
      valid_sr <= {valid_sr[CAS_LAT-2:0], issue};
      rd_ack   <= valid_sr[CAS_LAT-1];
      rd_data  <= valid_sr[CAS_LAT-1] ? rd_sdram_data : 16'h0;
    end
  end

  // Words still in flight keep the engine from signalling completion.
  assign busy = issue | (|valid_sr);

endmodule

// File: rtl/sdram_pro_read.sv
// Full-page burst read engine: ACTIVE, READ, BURST_TERMINATE after len words,
// PRECHARGE all banks, then a one-cycle rd_end once all words are delivered.
module sdram_pro_read
  import sdram_pro_read_pkg::*;
#(
  parameter int          CAS_LAT   = 3,
  parameter int          CNT_TRCD  = 2,
  parameter int          CNT_TRP   = 2,
  parameter logic [11:0] IDLE_ADDR = 12'hfff
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic        init_end,
  input  logic        rd_en,
  input  logic [22:0] rd_addr,
  input  logic [9:0]  rd_burst_len,
  input  logic [15:0] rd_sdram_data,
  output logic [3:0]  rd_sdram_cmd,
  output logic [11:0] rd_sdram_addr,
  output logic [1:0]  rd_sdram_bank,
  output logic        rd_ack,
  output logic [15:0] rd_data,
  output logic        rd_end
);

  rd_state_t   state, state_next;
  logic [9:0]  cnt;
  logic [22:0] addr_lat;
  logic [9:0]  len_lat;
  logic        start;
  logic        issue, issue_next;
  logic        cap_busy;
  logic [3:0]  cmd_next;
  logic [11:0] addr_next;
  logic [1:0]  bank_next;
  logic        end_next;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state         <= RD_IDLE;
      cnt           <= 10'd0;
      addr_lat      <= 23'd0;
      len_lat       <= 10'd1;
      issue         <= 1'b0;
      rd_sdram_cmd  <= CMD_NOP;
      rd_sdram_addr <= IDLE_ADDR;
      rd_sdram_bank <= 2'b11;
      rd_end        <= 1'b0;
    end else begin
      state         <= state_next;
      cnt           <= (state_next != state) ? 10'd0 : cnt + 10'd1;
      issue         <= issue_next;
      rd_sdram_cmd  <= cmd_next;
      rd_sdram_addr <= addr_next;
      rd_sdram_bank <= bank_next;
      rd_end        <= end_next;
      if (start) begin
        addr_lat <= rd_addr;
        len_lat  <= clamp_burst(rd_burst_len);
      end
    end
  end

  // Bus outputs are decoded from the current state and registered, so each
  // state's command appears one cycle after the state itself.
  always_comb begin
    state_next = state;
    start      = 1'b0;
    issue_next = 1'b0;
    cmd_next   = CMD_NOP;
    addr_next  = IDLE_ADDR;
    bank_next  = 2'b11;
    end_next   = 1'b0;
    case (state)
      RD_IDLE: begin
        if (init_end && rd_en) begin
          start      = 1'b1;
          state_next = RD_ACTIVE;
        end
      end
      RD_ACTIVE: begin
        cmd_next   = CMD_ACTIVE;
        addr_next  = addr_lat[ROW_HI:ROW_LO];
        bank_next  = addr_lat[BANK_HI:BANK_LO];
        state_next = RD_TRCD;
      end
      RD_TRCD: begin
        if (cnt == 10'(CNT_TRCD - 1))
          state_next = RD_READ;
      end
      RD_READ: begin
        cmd_next   = CMD_READ;
        addr_next  = {3'b000, addr_lat[COL_HI:COL_LO]};
        bank_next  = addr_lat[BANK_HI:BANK_LO];
        issue_next = 1'b1;
        state_next = (len_lat == 10'd1) ? RD_TERMINATE : RD_READ_DATA;
      end
      RD_READ_DATA: begin
        issue_next = 1'b1;
        if (cnt == len_lat - 10'd2)
          state_next = RD_TERMINATE;
      end
      RD_TERMINATE: begin
        cmd_next   = CMD_BURST_TERM;
        state_next = RD_PRECHARGE;
      end
      RD_PRECHARGE: begin
        cmd_next   = CMD_PRECHARGE;
        addr_next  = PRECHARGE_ALL;
        bank_next  = 2'b00;
        state_next = RD_TRP;
      end
      RD_TRP: begin
        if (cnt == 10'(CNT_TRP - 1))
          state_next = RD_END;
      end
      RD_END: begin
        if (!cap_busy) begin
          end_next = 1'b1;
          if (init_end && rd_en) begin
            start      = 1'b1;
            state_next = RD_ACTIVE;
          end else begin
            state_next = RD_IDLE;
          end
        end
      end
      default: state_next = RD_IDLE;
    endcase
  end

  sdram_pro_rd_capture #(
    .CAS_LAT(CAS_LAT)
  ) u_capture (
    .sys_clk      (sys_clk),
    .sys_rst_n    (sys_rst_n),
    .issue        (issue),
    .rd_sdram_data(rd_sdram_data),
    .busy         (cap_busy),
    .rd_ack       (rd_ack),
    .rd_data      (rd_data)
  );

endmodule

// File: tb/tb_sdram_pro_read.sv
// Directed bench for sdram_pro_read: bus command timing, capture data order,
// burst clamping, request gating, mid-burst reset and back-to-back reads.
module tb_sdram_pro_read;

  localparam logic [3:0] NOP = 4'b0111;
  localparam logic [3:0] ACT = 4'b0011;
  localparam logic [3:0] RD  = 4'b0101;
  localparam logic [3:0] BT  = 4'b0110;
  localparam logic [3:0] PRE = 4'b0010;
  localparam int CL = 3;

  logic        sys_clk;
  logic        sys_rst_n;
  logic        init_end;
  logic        rd_en;
  logic [22:0] rd_addr;
  logic [9:0]  rd_burst_len;
  logic [15:0] rd_sdram_data;
  logic [3:0]  rd_sdram_cmd;
  logic [11:0] rd_sdram_addr;
  logic [1:0]  rd_sdram_bank;
  logic        rd_ack;
  logic [15:0] rd_data;
  logic        rd_end;

  int cyc;
  int tests;
  int fails;
  int act_cnt, act_cyc, rd_cyc, bt_cyc, pre_cyc;
  int ack_cnt, ack_idx, first_ack_cyc, last_ack_cyc;
  int end_cnt, end_cyc, first_end_cyc, data_err;
  logic [11:0] act_addr, rd_addr_obs, pre_addr;
  logic [1:0]  act_bank, rd_bank_obs, pre_bank;

  sdram_pro_read dut (
    .sys_clk      (sys_clk),
    .sys_rst_n    (sys_rst_n),
    .init_end     (init_end),
    .rd_en        (rd_en),
    .rd_addr      (rd_addr),
    .rd_burst_len (rd_burst_len),
    .rd_sdram_data(rd_sdram_data),
    .rd_sdram_cmd (rd_sdram_cmd),
    .rd_sdram_addr(rd_sdram_addr),
    .rd_sdram_bank(rd_sdram_bank),
    .rd_ack       (rd_ack),
    .rd_data      (rd_data),
    .rd_end       (rd_end)
  );

  initial begin
    sys_clk = 1'b0;
    forever #5 sys_clk = ~sys_clk;
  end

  // DQ carries 16'hA000 + cycle number, so every word identifies its own cycle.
  initial begin
    cyc = 0;
    rd_sdram_data = 16'h0;
    forever begin
      @(posedge sys_clk);
      cyc = cyc + 1;
      #1 rd_sdram_data = 16'hA000 + cyc[15:0];
    end
  end

  task automatic clearLog();
    act_cnt = 0; act_cyc = 0; rd_cyc = 0; bt_cyc = 0; pre_cyc = 0;
    ack_cnt = 0; ack_idx = 0; first_ack_cyc = 0; last_ack_cyc = 0;
    end_cnt = 0; end_cyc = 0; first_end_cyc = 0; data_err = 0;
    act_addr = 12'h0; rd_addr_obs = 12'h0; pre_addr = 12'h0;
    act_bank = 2'b0; rd_bank_obs = 2'b0; pre_bank = 2'b0;
  endtask

  task automatic monitorLoop();
    logic [15:0] exp_data;
    forever begin
      @(negedge sys_clk);
      case (rd_sdram_cmd)
        ACT: begin
          act_cnt = act_cnt + 1; act_cyc = cyc;
          act_addr = rd_sdram_addr; act_bank = rd_sdram_bank;
        end
        RD: begin
          rd_cyc = cyc; rd_addr_obs = rd_sdram_addr; rd_bank_obs = rd_sdram_bank;
          ack_idx = 0;
        end
        BT: bt_cyc = cyc;
        PRE: begin
          pre_cyc = cyc; pre_addr = rd_sdram_addr; pre_bank = rd_sdram_bank;
        end
        default: ;
      endcase
      if (rd_ack) begin
        if (ack_idx == 0) first_ack_cyc = cyc;
        last_ack_cyc = cyc;
        ack_cnt = ack_cnt + 1;
        exp_data = 16'hA000 + 16'(rd_cyc + CL + ack_idx);
        if (rd_data !== exp_data) data_err = data_err + 1;
        ack_idx = ack_idx + 1;
      end else if (rd_data !== 16'h0) begin
        data_err = data_err + 1;
      end
      if (rd_end) begin
        end_cnt = end_cnt + 1;
        if (end_cnt == 1) first_end_cyc = cyc;
        end_cyc = cyc;
      end
    end
  endtask

  task automatic checkOutput(input string tag, input int observed, input int expected);
    tests = tests + 1;
    assert (observed === expected) else begin
      fails = fails + 1;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge sys_clk);
  endtask

  task automatic waitAct(input int n, input string tag);
    int k;
    k = 0;
    while (act_cnt < n && k < 40) begin @(negedge sys_clk); k++; end
    checkOutput(tag, int'(act_cnt >= n), 1);
  endtask

  task automatic waitRead(input string tag);
    int k;
    k = 0;
    while (rd_cyc == 0 && k < 40) begin @(negedge sys_clk); k++; end
    checkOutput(tag, int'(rd_cyc != 0), 1);
  endtask

  task automatic waitEnd(input int n, input string tag);
    int k;
    k = 0;
    while (end_cnt < n && k < 1200) begin @(negedge sys_clk); k++; end
    checkOutput(tag, int'(end_cnt >= n), 1);
  endtask

  task automatic applyStimulus(input logic [22:0] addr, input logic [9:0] len, input string tag);
    clearLog();
    rd_addr = addr;
    rd_burst_len = len;
    rd_en = 1'b1;
    waitAct(1, {tag, "_act_timeout"});
    rd_en = 1'b0;
    waitEnd(1, {tag, "_end_timeout"});
    idle(6);
  endtask

  task automatic verifyOp(input string p, input logic [1:0] bank, input logic [11:0] row,
                          input logic [8:0] col, input int len);
    checkOutput({p, "_act_addr"}, int'(act_addr), int'(row));
    checkOutput({p, "_act_bank"}, int'(act_bank), int'(bank));
    checkOutput({p, "_trcd"}, rd_cyc - act_cyc, 3);
    checkOutput({p, "_rd_addr"}, int'(rd_addr_obs), int'({3'b000, col}));
    checkOutput({p, "_rd_bank"}, int'(rd_bank_obs), int'(bank));
    checkOutput({p, "_bt_cyc"}, bt_cyc - rd_cyc, len);
    checkOutput({p, "_pre_cyc"}, pre_cyc - rd_cyc, len + 1);
    checkOutput({p, "_pre_addr"}, int'(pre_addr), 32'h400);
    checkOutput({p, "_pre_bank"}, int'(pre_bank), 0);
    checkOutput({p, "_ack_cnt"}, ack_cnt, len);
    checkOutput({p, "_first_ack"}, first_ack_cyc - rd_cyc, CL + 1);
    checkOutput({p, "_last_ack"}, last_ack_cyc - rd_cyc, len + CL);
    checkOutput({p, "_end_cyc"}, end_cyc - rd_cyc, len + 4);
    checkOutput({p, "_end_cnt"}, end_cnt, 1);
    checkOutput({p, "_data"}, data_err, 0);
  endtask

  task automatic checkIdleBus(input string p);
    checkOutput({p, "_cmd"}, int'(rd_sdram_cmd), int'(NOP));
    checkOutput({p, "_addr"}, int'(rd_sdram_addr), 32'hfff);
    checkOutput({p, "_bank"}, int'(rd_sdram_bank), 3);
  endtask

  initial begin
    tests = 0;
    fails = 0;
    sys_rst_n = 1'b0;
    init_end = 1'b0;
    rd_en = 1'b0;
    rd_addr = 23'd0;
    rd_burst_len = 10'd0;
    clearLog();
    fork
      monitorLoop();
    join_none

    // Reset state
    idle(3);
    checkIdleBus("rst");
    checkOutput("rst_ack", int'(rd_ack), 0);
    checkOutput("rst_data", int'(rd_data), 0);
    checkOutput("rst_end", int'(rd_end), 0);
    sys_rst_n = 1'b1;
    idle(2);

    // Gating on init_end, then single-word read
    clearLog();
    rd_addr = {2'b01, 12'h123, 9'h005};
    rd_burst_len = 10'd1;
    rd_en = 1'b1;
    idle(5);
    checkOutput("gate_no_act", act_cnt, 0);
    checkIdleBus("gate");
    init_end = 1'b1;
    waitAct(1, "gate_act_timeout");
    rd_en = 1'b0;
    waitEnd(1, "single_end_timeout");
    idle(6);
    verifyOp("single", 2'b01, 12'h123, 9'h005, 1);

    // Full page and burst-length clamps
    applyStimulus({2'b10, 12'h0AB, 9'h100}, 10'd512, "full");
    verifyOp("full", 2'b10, 12'h0AB, 9'h100, 512);
    applyStimulus({2'b00, 12'h456, 9'h1FF}, 10'd0, "len0");
    verifyOp("len0", 2'b00, 12'h456, 9'h1FF, 1);
    applyStimulus({2'b11, 12'h001, 9'h000}, 10'h3ff, "len3ff");
    verifyOp("len3ff", 2'b11, 12'h001, 9'h000, 512);

    // Request and address changes mid-burst are ignored
    clearLog();
    rd_addr = {2'b11, 12'h3C0, 9'h1F0};
    rd_burst_len = 10'd16;
    rd_en = 1'b1;
    waitAct(1, "toggle_act_timeout");
    rd_en = 1'b0;
    waitRead("toggle_rd_timeout");
    for (int i = 0; i < 4; i++) begin
      rd_en = i[0];
      rd_addr = 23'($urandom);
      rd_burst_len = 10'($urandom);
      @(negedge sys_clk);
    end
    rd_en = 1'b0;
    waitEnd(1, "toggle_end_timeout");
    idle(6);
    verifyOp("toggle", 2'b11, 12'h3C0, 9'h1F0, 16);

    // Reset at C0+3 of a len=8 read
    clearLog();
    rd_addr = {2'b01, 12'h777, 9'h010};
    rd_burst_len = 10'd8;
    rd_en = 1'b1;
    waitAct(1, "mrst_act_timeout");
    rd_en = 1'b0;
    waitRead("mrst_rd_timeout");
    do begin
      @(posedge sys_clk);
      #2;
    end while (cyc < rd_cyc + 3);
    sys_rst_n = 1'b0;
    init_end = 1'b0;
    #1;
    checkIdleBus("mrst");
    checkOutput("mrst_ack", int'(rd_ack), 0);
    checkOutput("mrst_data", int'(rd_data), 0);
    checkOutput("mrst_end", int'(rd_end), 0);
    idle(2);
    sys_rst_n = 1'b1;
    clearLog();
    idle(3);
    init_end = 1'b1;
    idle(20);
    checkOutput("mrst_stray_ack", ack_cnt, 0);
    checkOutput("mrst_stray_end", end_cnt, 0);
    checkOutput("mrst_stray_act", act_cnt, 0);

    // Back-to-back with rd_en held high
    clearLog();
    rd_addr = {2'b10, 12'h222, 9'h020};
    rd_burst_len = 10'd4;
    rd_en = 1'b1;
    waitAct(2, "b2b_act_timeout");
    rd_en = 1'b0;
    waitEnd(2, "b2b_end_timeout");
    idle(6);
    checkOutput("b2b_act_cnt", act_cnt, 2);
    checkOutput("b2b_end_cnt", end_cnt, 2);
    checkOutput("b2b_ack_cnt", ack_cnt, 8);
    checkOutput("b2b_gap", act_cyc - first_end_cyc, 1);
    checkOutput("b2b_data", data_err, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/sdram_pro_read.md
Name: sdram_pro_read

Overview:
Full-page burst read engine for the SDRAM controller; the read-direction counterpart of the page-burst write engine.
- On a granted read request it opens the row and issues READ.
- It captures 1..512 words arriving CAS_LAT cycles later and truncates the burst with BURST_TERMINATE.
- It then precharges, waits tRP and pulses rd_end.
- Sits under the arbiter alongside init/refresh/write; captured words feed the read FIFO.

Parameters:
CAS_LAT, 3, CAS latency programmed into the mode register (2 or 3)
CNT_TRCD, 2, NOP cycles between ACTIVE and READ on the bus
CNT_TRP, 2, NOP cycles between PRECHARGE and rd_end
IDLE_ADDR, 12'hfff, address driven when no command is active

Ports:
sys_clk  in  1  system clock, all logic on rising edge
sys_rst_n  in  1  asynchronous active-low reset
init_end  in  1  SDRAM initialisation complete
rd_en  in  1  read request/grant from arbiter, sampled only in IDLE
rd_addr  in  23  [22:21] bank, [20:9] row, [8:0] start column
rd_burst_len  in  10  words to read, 1..512
rd_sdram_data  in  16  SDRAM DQ input
rd_sdram_cmd  out  4  command code per defines.v
rd_sdram_addr  out  12  SDRAM address bus
rd_sdram_bank  out  2  SDRAM bank address
rd_ack  out  1  rd_data valid this cycle (FIFO write enable)
rd_data  out  16  captured read word, 16'h0 when rd_ack low
rd_end  out  1  one-cycle pulse: operation finished, bank precharged

Behaviour:
- Reset (async, any state): state IDLE; rd_sdram_cmd NO_OPERATION; rd_sdram_addr IDLE_ADDR; rd_sdram_bank 2'b11; rd_ack 0; rd_data 0; rd_end 0; all counters and pipeline cleared. Mid-burst reset abandons the burst with no terminate/precharge; init re-runs.
- All command/address/bank outputs are registered: state X drives its command on the bus in the following cycle.
- States: IDLE -> ACTIVE -> TRCD -> READ -> READ_DATA -> TERMINATE -> PRECHARGE -> TRP -> END -> IDLE.
- IDLE: leave only when init_end && rd_en. rd_addr and rd_burst_len are latched on that edge; later changes are ignored. rd_en deasserting mid-operation is ignored.
- Burst length clamp: latched 0 -> 1; values >512 -> 512.
- ACTIVE (bus cycle A0): cmd ACTIVE, addr = row, bank = bank.
- TRCD: CNT_TRCD cycles of NOP with IDLE_ADDR and bank 2'b11. READ appears at A0+CNT_TRCD+1.
- READ (bus cycle C0): cmd READ, addr = {3'b000, column}, so A10=0 (no auto-precharge), bank = latched bank.
- READ_DATA: NOP while the burst counter runs.
- BURST_TERMINATE on the bus at exactly C0+len. Wrap at column 511 -> 0 is performed by the SDRAM and needs no logic here.
- PRECHARGE on the bus at C0+len+1 with addr 12'h400 (A10=1, all banks), bank 2'b00.
- TRP: CNT_TRP NOP cycles.
- END: rd_end=1 for one cycle. END is held (NOP) until the capture pipeline is empty, so rd_end is never asserted at or before the last rd_ack.
- Capture: word k is on DQ at C0+CAS_LAT+k, k=0..len-1. It is registered into rd_data with rd_ack=1 at C0+CAS_LAT+1+k. rd_ack is high for exactly len consecutive cycles.
- Capture timing is driven by a CAS_LAT-deep valid shift register, not by the state. Words on DQ after the terminate window are never acknowledged.
- Defaults, len=L: last rd_ack at C0+L+3; rd_end at C0+L+4.
- Back-to-back: rd_en held high re-enters ACTIVE on the cycle after END.

Decomposition:
- Command codes (NO_OPERATION, ACTIVE, READ, BURST_TERMINATE, PRECHARGE) come from the shared defines.v; no new codes are added.
- State encoding and address field slice constants (bank/row/column bit ranges) go in the same shared defines include, reused by the write engine.
- One sub-module: sdram_pro_rd_capture, the CAS_LAT valid shift register plus the data register producing rd_ack/rd_data.

Test Plan:
- Single word: rd_addr={2'b01,12'h123,9'h005}, len=1 -> ACTIVE bank 1 addr 12'h123; READ addr 12'h005 three cycles later; BURST_TERMINATE at C0+1; one rd_ack at C0+4 with DQ data; rd_end at C0+5.
- Full page: len=512, start column 9'h100, DQ driven with incrementing pattern -> exactly 512 rd_ack cycles with matching in-order data; BT at C0+512; PRECHARGE addr 12'h400 at C0+513.
- Clamp: len=0 -> behaves as len=1. len=10'h3ff -> exactly 512 acks.
- Gating: rd_en=1 with init_end=0 -> stays IDLE with NOP/12'hfff/2'b11. Then init_end=1 -> ACTIVE next bus cycle. Toggling rd_en and rd_addr mid-burst -> no effect.
- Reset mid-burst: assert sys_rst_n=0 at C0+3 of a len=8 read -> all outputs take reset values immediately. After release, no stray rd_ack or rd_end occurs.
- Back-to-back: rd_en held through two len=4 reads -> second ACTIVE on the bus the cycle after the first rd_end, 8 acks total, rd_end pulses twice.
